cnn_layer_seq: RTL and testbench

Layer sequencer for the CNN accelerator, and the issuing end of the 8-bit `ctrl` / `return_ctrl` command protocol. The CNN control decoder turns each `ctrl` code into layer enables and memory-counter resets, and echoes the code on `return_ctrl` when the layer completes. This block generates those codes in order:

- 1 image load
- 2 conv1
- 3 pool1
- 4 conv2
- 5 pool2
- 6 FC

It waits for each echo, returns `ctrl` to 0 between layers so all memory counters reset, and reports done, timeout or abort to the host register file.

---
 rtl/cnn_layer_seq.sv | 130 +++++++++++++
 tb/tb_cnn_layer_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: issues ctrl codes 1..6 in order and waits for each echo on return_ctrl.
// Optional build macro CNN_SEQ_PERF_EN adds the run_cycles performance counter output.
module cnn_layer_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned TO_W           = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        img_ready,
  input  logic [7:0]  return_ctrl,
  output logic [7:0]  ctrl,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  step,
  output logic [2:0]  err_step
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0] run_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DONE, ERR} state_t;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [2:0]      step_n, err_step_n;
  logic            error_n;
  logic [7:0]      ret_q;
  logic [TO_W-1:0] to_cnt;
  logic            ack, to_hit, start_ok;

  // The echo is combinational from ctrl, so only the registered copy is compared.
  assign ack    = (ret_q == {5'd0, step}) && ((step != 3'd1) || img_ready);
  assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_n    = state;
    step_n     = step;
    error_n    = error;
    err_step_n = err_step;
    start_ok   = 1'b0;
    if (abort) begin
      state_n    = IDLE;
      step_n     = 3'd0;
      error_n    = 1'b0;
      err_step_n = 3'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            start_ok   = 1'b1;
            state_n    = CLEAR;
            step_n     = 3'd1;
            error_n    = 1'b0;
            err_step_n = 3'd0;
          end else if (state == DONE) begin
            state_n = IDLE;
          end
        end
        CLEAR: state_n = ISSUE;
        ISSUE: begin
          if (ack) begin
            if (step == 3'd6) begin
              state_n = DONE;
            end else begin
              step_n  = step + 3'd1;
              state_n = CLEAR;
            end
          end else if (to_hit) begin
            error_n    = 1'b1;
            err_step_n = step;
            state_n    = ERR;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step     <= 3'd0;
      error    <= 1'b0;
      err_step <= 3'd0;
      ctrl     <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ret_q    <= 8'd0;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      error    <= error_n;
      err_step <= err_step_n;
      // Outputs are decoded from the next state so they line up with it.
      ctrl     <= (state_n == ISSUE) ? {5'd0, step_n} : 8'd0;
      busy     <= (state_n == CLEAR) || (state_n == ISSUE);
      done     <= (state_n == DONE);
      ret_q    <= (state == CLEAR) ? 8'd0 : return_ctrl;
      to_cnt   <= (state == ISSUE) ? to_cnt + TO_W'(1) : '0;
    end
  end

`ifdef CNN_SEQ_PERF_EN
  logic [31:0] perf_cnt, perf_n;

  always_comb begin
    perf_n = perf_cnt;
    if (busy && (perf_cnt != 32'hFFFF_FFFF)) perf_n = perf_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt   <= 32'd0;
      run_cycles <= 32'd0;
    end else begin
      perf_cnt <= start_ok ? 32'd0 : perf_n;
      // Include the final busy cycle that leads into DONE.
      if (state_n == DONE) run_cycles <= perf_n;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: nominal table plus delayed image, stall, abort, bad echo and reset sequences.
module tb_cnn_layer_seq;
  logic        clk = 1'b0;
  logic        reset_n, start, abort, img_ready;
  logic [7:0]  return_ctrl, ctrl;
  logic        busy, done, error;
  logic [2:0]  step, err_step;
`ifdef CNN_SEQ_PERF_EN
  logic [31:0] run_cycles;
`endif

  logic [7:0]  blk;
  logic        bad_en;
  int          errors = 0;
  int          checks = 0;

  cnn_layer_seq #(.TIMEOUT_CYCLES(100), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .img_ready(img_ready), .return_ctrl(return_ctrl), .ctrl(ctrl),
    .busy(busy), .done(done), .error(error), .step(step), .err_step(err_step)
`ifdef CNN_SEQ_PERF_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Decoder model: immediate echo, optionally withholding one code or answering 3 with 5.
  always_comb begin
    return_ctrl = ctrl;
    if (bad_en && ctrl == 8'd3) return_ctrl = 8'd5;
    else if (blk != 8'd0 && ctrl == blk) return_ctrl = 8'd0;
  end

  typedef struct packed {
    logic       start;
    logic [7:0] ctrl;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } vec_t;

  vec_t vec [0:21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_ctrl(input logic [7:0] code, input int budget, input string nm);
    int n = 0;
    while (ctrl !== code && n < budget) begin
      @(negedge clk); n++;
    end
    chk(nm, ctrl, code);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    chk(nm, seen, 1);
    chk({nm, "_step"}, step, 6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1'b1, 8'd0, 1'b0, 1'b0, 3'd0};
    vec[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd1};
    vec[2]  = '{1'b0, 8'd1, 1'b1, 1'b0, 3'd1};
    vec[3]  = '{1'b0, 8'd1, 1'b1, 1'b0, 3'd1};
    vec[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
    vec[5]  = '{1'b0, 8'd2, 1'b1, 1'b0, 3'd2};
    vec[6]  = '{1'b0, 8'd2, 1'b1, 1'b0, 3'd2};
    vec[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd3};
    vec[8]  = '{1'b0, 8'd3, 1'b1, 1'b0, 3'd3};
    vec[9]  = '{1'b0, 8'd3, 1'b1, 1'b0, 3'd3};
    vec[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd4};
    vec[11] = '{1'b0, 8'd4, 1'b1, 1'b0, 3'd4};
    vec[12] = '{1'b0, 8'd4, 1'b1, 1'b0, 3'd4};
    vec[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd5};
    vec[14] = '{1'b0, 8'd5, 1'b1, 1'b0, 3'd5};
    vec[15] = '{1'b0, 8'd5, 1'b1, 1'b0, 3'd5};
    vec[16] = '{1'b0, 8'd0, 1'b1, 1'b0, 3'd6};
    vec[17] = '{1'b0, 8'd6, 1'b1, 1'b0, 3'd6};
    vec[18] = '{1'b0, 8'd6, 1'b1, 1'b0, 3'd6};
    vec[19] = '{1'b0, 8'd0, 1'b0, 1'b1, 3'd6};
    vec[20] = '{1'b0, 8'd0, 1'b0, 1'b0, 3'd6};
    vec[21] = '{1'b0, 8'd0, 1'b0, 1'b0, 3'd6};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; img_ready = 1'b1;
    blk = 8'd0; bad_en = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_step", step, 0);
    chk("rst_err_step", err_step, 0);
    reset_n = 1'b1;

    // Nominal run, start high in cycle 0
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk($sformatf("nom_ctrl_c%0d", i), ctrl, vec[i].ctrl);
      chk($sformatf("nom_busy_c%0d", i), busy, vec[i].busy);
      chk($sformatf("nom_done_c%0d", i), done, vec[i].done);
      chk($sformatf("nom_step_c%0d", i), step, vec[i].step);
      start = vec[i].start;
    end
    start = 1'b0;
`ifdef CNN_SEQ_PERF_EN
    chk("nom_run_cycles", run_cycles, 18);
`endif

    // Delayed image: ctrl holds 1 for 50 cycles
    begin
      int held = 0;
      img_ready = 1'b0;
      pulse_start();
      @(negedge clk);
      for (int k = 0; k < 50; k++) begin
        if (ctrl == 8'd1 && step == 3'd1) held++;
        @(negedge clk);
      end
      chk("img_hold_cycles", held, 50);
      img_ready = 1'b1;
      @(negedge clk);
      chk("img_adv_ctrl", ctrl, 0);
      chk("img_adv_step", step, 2);
      wait_done(40, "img_done");
    end

    // Layer stall on code 4
    begin
      int early = 0;
      blk = 8'd4;
      pulse_start();
      wait_ctrl(8'd4, 30, "stall_reach4");
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (k < 100 && error) early++;
      end
      chk("stall_early_error", early, 0);
      chk("stall_error", error, 1);
      chk("stall_err_step", err_step, 4);
      chk("stall_ctrl", ctrl, 0);
      chk("stall_busy", busy, 0);
      blk = 8'd0;
      pulse_start();
      chk("restart_error", error, 0);
      chk("restart_err_step", err_step, 0);
      wait_done(40, "restart_done");
    end

    // Abort coinciding with step-3 ack
    begin
      int bad = 0;
      pulse_start();
      wait_ctrl(8'd3, 30, "abort_reach3");
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ctrl", ctrl, 0);
      chk("abort_step", step, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done || ctrl != 8'd0) bad++;
      end
      chk("abort_quiet", bad, 0);
    end

    // Bad echo 5 for code 3 plus an ignored mid-run start
    begin
      int held = 0;
      bad_en = 1'b1;
      pulse_start();
      wait_ctrl(8'd3, 30, "bad_reach3");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (ctrl == 8'd3 && step == 3'd3) held++;
        @(negedge clk);
      end
      chk("bad_hold", held, 10);
      bad_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bad_adv_step", step, 4);
      chk("bad_adv_ctrl", ctrl, 0);
      @(negedge clk);
      chk("bad_next_ctrl", ctrl, 4);
      wait_done(30, "bad_done");
    end

    // Reset mid-run while ctrl is 5
    pulse_start();
    wait_ctrl(8'd5, 30, "mrst_reach5");
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_ctrl", ctrl, 0);
    chk("mrst_step", step, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_error", error, 0);
    chk("mrst_err_step", err_step, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start();
    wait_done(40, "mrst_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
